mode_status_reporter: RTL
=========================

// Module: mode_status_reporter
// PURPOSE
//  Transmit side of the scent/timer/pump command protocol. Watches the menu state
//  (scent_sel, timer_sel) and pump event pulses from the mode controller. Encodes
//  changes into the same one-byte codes the app sends and hands them to the UART TX
//  through a valid/ready byte handshake, so the Bluetooth app stays in sync with
//  local button actions. Optionally repeats the full status periodically.
// PARAMETERS
//  GAP_CYCLES      16         idle clocks forced between accepted bytes (0 = back-to-back)
//  REFRESH_CYCLES  5_000_000  period of full-status resend in clocks (0 = disabled; 5 s @ 1 MHz)
//  STARTUP_REPORT  1          1 = queue scent+timer report on the first cycle after reset
// PORTS
//  clk             in   1  system clock
//  reset           in   1  asynchronous, active-high reset
//  scent_sel       in   2  0=Cotton 1=Woody 2=Citrus, 3=invalid
//  timer_sel       in   2  0=30min 1=60min 2=120min, 3=invalid
//  pump_on_pulse   in   1  1-cycle pump-start event
//  pump_off_pulse  in   1  1-cycle pump-stop event
//  tx_ready        in   1  UART TX can accept a byte
//  tx_valid        out  1  tx_data valid, held until accepted
//  tx_data         out  8  byte code
//  busy            out  1  FSM not in IDLE or any pending flag set
// BEHAVIOUR
//  Reset (async, immediate):
//   - tx_valid=0, tx_data=8'h00, busy=0; FSM->IDLE; refresh counter=0.
//   - scent_prev=0, timer_prev=0; pend flags clear, except scent/timer pend =STARTUP_REPORT.
//   - Reset mid-byte drops tx_valid at once; the byte is lost, no resume.
//  Encoding:
//   - scent 0->8'h02, 1->8'h03, 2->8'h01.
//   - timer 0->8'h1E, 1->8'h3C, 2->8'h78.
//   - pump on->8'h04, off->8'h05.
//   - sel==3 is never sent: its pend flag is cleared at load time with no byte.
//  Change detect:
//   - Each edge: scent_prev<=scent_sel; scent_pend set if scent_sel!=scent_prev. Same for timer.
//   - pump_on/off pulse sets pump_pend and pump_code (04/05). Both in one cycle -> 05.
//     Newer pulse overwrites older unsent code.
//   - Flags coalesce: several changes before load produce ONE byte carrying the value
//     current at load time.
//  Refresh:
//   - Counter counts 0..REFRESH_CYCLES-1, free-running.
//   - On wrap, sets scent_pend and timer_pend.
//  FSM:
//   - IDLE: if any pend, at the next edge load the highest priority (pump > scent > timer)
//     into tx_data, set tx_valid, clear that pend, go SEND.
//     Event on the same edge as its clear -> the pend stays set.
//   - SEND: hold tx_data/tx_valid stable. On an edge with tx_ready=1, the byte is accepted:
//     tx_valid<=0, go GAP (or IDLE if GAP_CYCLES==0).
//   - GAP: count GAP_CYCLES clocks, then IDLE.
//  Latency:
//   - Sel change seen at edge k -> tx_valid high after edge k+1 (FSM idle, nothing pending).
//   - Max throughput: 1 byte per 2+GAP_CYCLES clocks.
//  tx_ready low indefinitely: stay in SEND, keep collecting pend flags, lose no event
//  types (values coalesce).
// TESTING
//  1 Reset, STARTUP_REPORT=1, sel 0/0, tx_ready=1 -> bytes 02 then 1E, GAP_CYCLES apart;
//    then idle, busy=0.
//  2 scent_sel 0->1->2 on consecutive cycles while tx_ready=0 -> once ready=1, exactly one
//    byte 01.
//  3 pump_on_pulse and timer_sel 0->2 same cycle -> 04 first, then 78; tx_data stable
//    while tx_valid&!tx_ready.
//  4 pump_on and pump_off pulses same cycle -> single byte 05; scent_sel=3 -> no byte.
//  5 REFRESH_CYCLES=100, no changes -> 02/1E pair each 100 clocks; GAP_CYCLES=0 ->
//    byte accepted every 2nd clock.
//  6 Assert reset while tx_valid=1 -> tx_valid=0 same cycle; after release only the
//    startup report is sent.

Source files
------------

// File: rtl/mode_status_reporter_if.sv
// Byte-stream bundle between the mode controller, the status reporter and the UART TX.
// master drives menu state, pump events and tx_ready; slave is the reporter itself.
interface mode_status_reporter_if;
    logic [1:0] scent_sel;
    logic [1:0] timer_sel;
    logic       pump_on_pulse;
    logic       pump_off_pulse;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;

    modport master (
        output scent_sel, timer_sel, pump_on_pulse, pump_off_pulse, tx_ready,
        input  tx_valid, tx_data, busy
    );

    modport slave (
        input  scent_sel, timer_sel, pump_on_pulse, pump_off_pulse, tx_ready,
        output tx_valid, tx_data, busy
    );
endinterface

// File: rtl/mode_status_reporter.sv
// Encodes local scent/timer/pump changes into one-byte app codes and streams them
// to the UART TX over a valid/ready handshake, with optional periodic full-status resend.
module mode_status_reporter #(
    parameter int GAP_CYCLES     = 16,
    parameter int REFRESH_CYCLES = 5_000_000,
    parameter int STARTUP_REPORT = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    mode_status_reporter_if.slave        bus
);
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_SEND    = 2'd1;
    localparam logic [1:0]  ST_GAP     = 2'd2;
    localparam logic        L_STARTUP  = (STARTUP_REPORT != 0) ? 1'b1 : 1'b0;
    localparam logic        L_REF_EN   = (REFRESH_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic        L_GAP_EN   = (GAP_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic [31:0] L_REF_LAST = (REFRESH_CYCLES > 0) ? 32'(REFRESH_CYCLES - 1) : 32'd0;
    localparam logic [31:0] L_GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

    function automatic logic [7:0] enc_scent(input logic [1:0] sel);
        case (sel)
            2'd0:    enc_scent = 8'h02;
            2'd1:    enc_scent = 8'h03;
            2'd2:    enc_scent = 8'h01;
            default: enc_scent = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] enc_timer(input logic [1:0] sel);
        case (sel)
            2'd0:    enc_timer = 8'h1E;
            2'd1:    enc_timer = 8'h3C;
            2'd2:    enc_timer = 8'h78;
            default: enc_timer = 8'h00;
        endcase
    endfunction

    logic [1:0]  r_state, w_state_nxt;
    logic [31:0] r_gap_cnt, w_gap_cnt_nxt;
    logic [31:0] r_refresh_cnt, w_refresh_cnt_nxt;
    logic [1:0]  r_scent_prev, r_timer_prev;
    logic        r_pump_pend, r_scent_pend, r_timer_pend;
    logic        w_pump_pend_nxt, w_scent_pend_nxt, w_timer_pend_nxt;
    logic [7:0]  r_pump_code, w_pump_code_nxt;
    logic        r_tx_valid, w_tx_valid_nxt;
    logic [7:0]  r_tx_data, w_tx_data_nxt;
    logic        r_busy, w_busy_nxt;
    logic        w_refresh_wrap;
    logic        w_clr_pump, w_clr_scent, w_clr_timer;

    // Next-state logic: FSM, pending-flag bookkeeping and refresh timer.
    always_comb begin
        w_state_nxt    = r_state;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_tx_valid_nxt = r_tx_valid;
        w_tx_data_nxt  = r_tx_data;
        w_clr_pump     = 1'b0;
        w_clr_scent    = 1'b0;
        w_clr_timer    = 1'b0;

        w_refresh_wrap = L_REF_EN && (r_refresh_cnt == L_REF_LAST);
        if (w_refresh_wrap || !L_REF_EN) begin
            w_refresh_cnt_nxt = 32'd0;
        end else begin
            w_refresh_cnt_nxt = r_refresh_cnt + 32'd1;
        end

        case (r_state)
            ST_IDLE: begin
                // An invalid selector (3) only drops its flag; no byte goes out.
                if (r_pump_pend) begin
                    w_clr_pump     = 1'b1;
                    w_tx_data_nxt  = r_pump_code;
                    w_tx_valid_nxt = 1'b1;
                    w_state_nxt    = ST_SEND;
                end else if (r_scent_pend) begin
                    w_clr_scent = 1'b1;
                    if (bus.scent_sel != 2'd3) begin
                        w_tx_data_nxt  = enc_scent(bus.scent_sel);
                        w_tx_valid_nxt = 1'b1;
                        w_state_nxt    = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_timer_pend) begin
                    w_clr_timer = 1'b1;
                    if (bus.timer_sel != 2'd3) begin
                        w_tx_data_nxt  = enc_timer(bus.timer_sel);
                        w_tx_valid_nxt = 1'b1;
                        w_state_nxt    = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    w_tx_valid_nxt = 1'b0;
                    w_gap_cnt_nxt  = 32'd0;
                    w_state_nxt    = L_GAP_EN ? ST_GAP : ST_IDLE;
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == L_GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_tx_valid_nxt = 1'b0;
            end
        endcase

        // A new event on the clearing edge wins, so nothing is lost.
        w_pump_pend_nxt  = (r_pump_pend & ~w_clr_pump) | bus.pump_on_pulse | bus.pump_off_pulse;
        w_scent_pend_nxt = (r_scent_pend & ~w_clr_scent) | (bus.scent_sel != r_scent_prev) | w_refresh_wrap;
        w_timer_pend_nxt = (r_timer_pend & ~w_clr_timer) | (bus.timer_sel != r_timer_prev) | w_refresh_wrap;

        if (bus.pump_off_pulse) begin
            w_pump_code_nxt = 8'h05;
        end else if (bus.pump_on_pulse) begin
            w_pump_code_nxt = 8'h04;
        end else begin
            w_pump_code_nxt = r_pump_code;
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE) | w_pump_pend_nxt | w_scent_pend_nxt | w_timer_pend_nxt;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_gap_cnt     <= 32'd0;
            r_refresh_cnt <= 32'd0;
            r_scent_prev  <= 2'd0;
            r_timer_prev  <= 2'd0;
            r_pump_pend   <= 1'b0;
            r_scent_pend  <= L_STARTUP;
            r_timer_pend  <= L_STARTUP;
            r_pump_code   <= 8'h00;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_refresh_cnt <= w_refresh_cnt_nxt;
            r_scent_prev  <= bus.scent_sel;
            r_timer_prev  <= bus.timer_sel;
            r_pump_pend   <= w_pump_pend_nxt;
            r_scent_pend  <= w_scent_pend_nxt;
            r_timer_pend  <= w_timer_pend_nxt;
            r_pump_code   <= w_pump_code_nxt;
            r_tx_valid    <= w_tx_valid_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign bus.busy     = r_busy;
endmodule
